hazard_scoreboard: RTL

// - Producer-side companion to operand forwarding: tracks in-flight writes from the multi-cycle unit
//   (DIV/REM, FDIV, FSQRT) and load-use hazards.
// - Raises a stall to the ID stage when an operand cannot be forwarded yet.
// - Sits beside the forwarding logic in the rv32imf core; once a write reaches WB, forwarding takes over.

---
 rtl/hazard_scoreboard_pkg.sv | 19 +
 rtl/sb_pending_vec.sv | 37 +++
 rtl/hazard_scoreboard.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard: register index, FSM state, destination descriptor.
package sb_pkg;

    typedef logic [4:0] reg_idx_t;

    typedef enum logic [1:0] {
        SB_IDLE = 2'd0,
        SB_BUSY = 2'd1,
        SB_FULL = 2'd2
    } sb_state_e;

    localparam int NUM_REGS = 32;

    typedef struct packed {
        reg_idx_t idx;
        logic     is_fp;
    } sb_dst_t;

endpackage

// File: rtl/sb_pending_vec.sv
// Per-register pending-bit array with one set port and one clear port; clear has priority.
module sb_pending_vec
    import sb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_en,
    input  reg_idx_t         set_idx,
    input  logic             clr_en,
    input  reg_idx_t         clr_idx,
    output logic [WIDTH-1:0] vec
);

    logic [WIDTH-1:0] vec_r;

    // Pending bits: set on issue, cleared on completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            vec_r <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (clr_en && (clr_idx == reg_idx_t'(i))) begin
                    vec_r[i] <= 1'b0;
                end else if (set_en && (set_idx == reg_idx_t'(i))) begin
                    vec_r[i] <= 1'b1;
                end else begin
                    vec_r[i] <= vec_r[i];
                end
            end
        end
    end

    assign vec = vec_r;

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight multi-cycle writes and load-use hazards, stalling ID when an operand is not forwardable.
// Define SCOREBOARD_FP_EN to enable the FP pending file, FP RAW/WAW, rs3 and FP load-use checks.
module hazard_scoreboard
    import sb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int NUM_REGS        = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                issue_valid_id,
    input  logic [4:0]          rs1_id,
    input  logic [4:0]          rs2_id,
    input  logic [4:0]          rs3_id,
    input  logic                rs1_fp_id,
    input  logic                rs2_fp_id,
    input  logic                rs3_used_id,
    input  logic [4:0]          rd_id,
    input  logic                rd_fp_id,
    input  logic                reg_write_id,
    input  logic                multicycle_id,
    input  logic                mem_read_exe,
    input  logic [4:0]          rd_exe,
    input  logic                rd_fp_exe,
    input  logic                mc_done,
    input  logic [4:0]          mc_rd,
    input  logic                mc_rd_fp,
    output logic                stall_id,
    output logic                mc_full,
    output logic [NUM_REGS-1:0] pending_int,
    output logic [NUM_REGS-1:0] pending_fp,
    output logic                sb_error
);

`ifdef SCOREBOARD_FP_EN
    localparam logic FP_EN = 1'b1;
`else
    localparam logic FP_EN = 1'b0;
`endif
    localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

    logic [2:0]          count_r;
    logic [2:0]          count_next_s;
    sb_state_e           state_r;
    logic                sb_error_r;
    logic [NUM_REGS-1:0] pend_fp_s;
    sb_dst_t             done_dst_s;
    logic                raw_s, waw_s, lu_s, struct_s, stall_s;
    logic                mc_issue_s, set_int_s, set_fp_s;
    logic                done_pend_s, done_exempt_s, err_empty_s, err_nopend_s, done_ok_s;
    logic                clr_int_s, clr_fp_s;

    assign done_dst_s = '{idx: mc_rd, is_fp: mc_rd_fp};

    // Hazard detection from registered pending state plus current ID/EXE fields.
    always_comb begin
        raw_s = (rs1_fp_id ? pend_fp_s[rs1_id] : pending_int[rs1_id])
              | (rs2_fp_id ? pend_fp_s[rs2_id] : pending_int[rs2_id])
              | (FP_EN & rs3_used_id & pend_fp_s[rs3_id]);
        waw_s = reg_write_id & (rd_fp_id ? pend_fp_s[rd_id] : pending_int[rd_id]);
        lu_s  = (mem_read_exe & ~rd_fp_exe & (rd_exe != 5'd0)
                 & ((~rs1_fp_id & (rs1_id == rd_exe)) | (~rs2_fp_id & (rs2_id == rd_exe))))
              | (FP_EN & mem_read_exe & rd_fp_exe
                 & ((rs1_fp_id & (rs1_id == rd_exe)) | (rs2_fp_id & (rs2_id == rd_exe))
                    | (rs3_used_id & (rs3_id == rd_exe))));
        struct_s = multicycle_id & (count_r == MAX_CNT);
        stall_s  = ~reset & issue_valid_id & (raw_s | waw_s | lu_s | struct_s);
    end

    // Issue/completion qualification; x0 and disabled-FP completions are never pending, so not errors.
    always_comb begin
        mc_issue_s    = issue_valid_id & ~stall_s & multicycle_id;
        set_int_s     = mc_issue_s & reg_write_id & ~rd_fp_id & (rd_id != 5'd0);
        set_fp_s      = FP_EN & mc_issue_s & reg_write_id & rd_fp_id;
        done_pend_s   = done_dst_s.is_fp ? pend_fp_s[done_dst_s.idx] : pending_int[done_dst_s.idx];
        done_exempt_s = (~done_dst_s.is_fp & (done_dst_s.idx == 5'd0)) | (done_dst_s.is_fp & ~FP_EN);
        err_empty_s   = mc_done & (count_r == 3'd0);
        err_nopend_s  = mc_done & (count_r != 3'd0) & ~done_pend_s & ~done_exempt_s;
        done_ok_s     = mc_done & ~err_empty_s & ~err_nopend_s;
        clr_int_s     = done_ok_s & ~done_dst_s.is_fp;
        clr_fp_s      = FP_EN & done_ok_s & done_dst_s.is_fp;
        case ({mc_issue_s, done_ok_s})
            2'b10:   count_next_s = count_r + 3'd1;
            2'b01:   count_next_s = count_r - 3'd1;
            default: count_next_s = count_r;
        endcase
    end

    // Occupancy counter, FSM and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r    <= 3'd0;
            state_r    <= SB_IDLE;
            sb_error_r <= 1'b0;
        end else begin
            count_r    <= count_next_s;
            sb_error_r <= sb_error_r | err_empty_s | err_nopend_s;
            case (state_r)
                SB_IDLE: begin
                    if (count_next_s == MAX_CNT)       state_r <= SB_FULL;
                    else if (count_next_s != 3'd0)     state_r <= SB_BUSY;
                    else                               state_r <= SB_IDLE;
                end
                SB_BUSY: begin
                    if (count_next_s == 3'd0)          state_r <= SB_IDLE;
                    else if (count_next_s == MAX_CNT)  state_r <= SB_FULL;
                    else                               state_r <= SB_BUSY;
                end
                SB_FULL: begin
                    if (count_next_s == 3'd0)          state_r <= SB_IDLE;
                    else if (count_next_s != MAX_CNT)  state_r <= SB_BUSY;
                    else                               state_r <= SB_FULL;
                end
                default: state_r <= SB_IDLE;
            endcase
        end
    end

    sb_pending_vec #(.WIDTH(NUM_REGS)) u_pend_int (
        .clk     (clk),
        .reset   (reset),
        .set_en  (set_int_s),
        .set_idx (rd_id),
        .clr_en  (clr_int_s),
        .clr_idx (done_dst_s.idx),
        .vec     (pending_int)
    );

`ifdef SCOREBOARD_FP_EN
    sb_pending_vec #(.WIDTH(NUM_REGS)) u_pend_fp (
        .clk     (clk),
        .reset   (reset),
        .set_en  (set_fp_s),
        .set_idx (rd_id),
        .clr_en  (clr_fp_s),
        .clr_idx (done_dst_s.idx),
        .vec     (pend_fp_s)
    );
`else
    assign pend_fp_s = {NUM_REGS{1'b0}} & {NUM_REGS{set_fp_s | clr_fp_s}};
`endif

    assign pending_fp = pend_fp_s;
    assign stall_id   = stall_s;
    assign mc_full    = ~reset & (state_r == SB_FULL);
    assign sb_error   = sb_error_r;

endmodule
